// File: rtl/flop_arb_pkg.sv
// Shared types and helpers for the flop-pair arbiter.
// Used by the top and the rotating-priority picker.
package flop_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Index width, never zero so tiny configs still get a real vector
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flop_pair_arbiter_rr_pick.sv
// Rotating-priority search: first requester at or after ptr,
// optionally skipping one index (the current owner).
module rr_pick
    import flop_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             exclude_en,
    input  logic [IDX_W-1:0] exclude_idx,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = int'(ptr) + k;
            if (c >= N_REQ) c = c - N_REQ;
            if (!found && req[c] &&
                !(exclude_en && c == int'(exclude_idx))) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/flop_pair_arbiter.sv
// Round-robin owner of a shared set/reset flop pair (q, qi).
// Owner loads its payload each edge; a hold limit forces rotation.
module flop_pair_arbiter
    import flop_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           s_in,
    input  logic [N_REQ-1:0]           r_in,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       q,
    output logic                       qi
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int HW    = idx_w(MAX_HOLD);
    localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [HW-1:0]    hold_cnt;

    logic             found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             own_req;
    logic             load;
    logic             take;
    logic             drop;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (req),
        .ptr         (ptr),
        .exclude_en  (state == ST_OWN),
        .exclude_idx (owner),
        .found       (found),
        .idx         (pick_idx)
    );

    assign next_ptr = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    assign own_req  = req[owner];
    assign load     = (state == ST_OWN) && own_req;

    // Hand off when idle, when the owner lets go, or at the hold limit
    assign take = found &&
                  ((state == ST_IDLE) ||
                   (!own_req || hold_cnt == HOLD_MAX));
    assign drop = (state == ST_OWN) && !own_req && !found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            q        <= 1'b0;
            qi       <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            if (load) begin
                q  <= s_in[owner];
                qi <= r_in[owner];
            end
            if (take) begin
                state    <= ST_OWN;
                grant    <= ONE << pick_idx;
                owner    <= pick_idx;
                busy     <= 1'b1;
                ptr      <= next_ptr;
                hold_cnt <= '0;
            end else if (drop) begin
                state <= ST_IDLE;
                grant <= '0;
                busy  <= 1'b0;
            end else if (load && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/flop_pair_arbiter.md
Name: flop_pair_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered set/reset flop pair (q, qi) among N_REQ requesters.
- Each requester presents a request plus a 2-bit payload (s, r). The granted requester's payload is loaded into the shared pair on each clock rising edge.
- A hold limit forces rotation so no requester can monopolise the pair.
- Sits between lab stimulus/requester logic and the shared storage flops. It owns those flops internally.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive loads by one owner while another requester waits (>=1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- s_in  input  N_REQ  per-requester payload bit, loaded into q.
- r_in  input  N_REQ  per-requester payload bit, loaded into qi.
- grant  output  N_REQ  registered one-hot grant (all-zero when idle).
- owner  output  $clog2(N_REQ)  index of current owner, valid when busy=1.
- busy  output  1  high in OWN state.
- q  output  1  shared flop, stored s.
- qi  output  1  shared flop, stored r.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any time, including mid-ownership) forces:
  - state=IDLE, grant=0, owner=0, busy=0, q=0, qi=0;
  - rr pointer ptr=0, hold_cnt=0.
  - No partial load completes on the reset edge.
- Selection (rr_pick): lowest index i in the order ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 with req[i]=1, optionally excluding the current owner.
- Whenever grant changes to a new owner k: ptr<=k+1 mod N_REQ, hold_cnt<=0.
- FSM, IDLE:
  - No loads; q/qi hold their values.
  - If any req=1 at an edge: grant<=onehot(pick), owner<=pick, busy<=1, state<=OWN.
  - Grant latency is 1 cycle from req sampled high.
- FSM, OWN with owner o, at each edge:
  - req[o]=1: q<=s_in[o], qi<=r_in[o].
    - If hold_cnt==MAX_HOLD-1 and another req is pending: hand off to pick (excluding o) on the same edge. The final load still occurs.
    - Otherwise hold_cnt<=min(hold_cnt+1, MAX_HOLD-1), saturating. The owner keeps the grant indefinitely if it is alone.
  - req[o]=0: no load.
    - If another req is pending: hand off to pick (excluding o).
    - Otherwise: grant<=0, busy<=0, state<=IDLE. ptr is still o+1.
- Loads occur only on edges where grant[o]=1 is already registered and req[o]=1. Payload from non-granted requesters is ignored.
- Handoff is back-to-back (OWN->OWN): no idle cycle, and the new owner loads on the following edge.
- grant is always one-hot or zero, never multi-hot. owner/busy change on the same edge as grant.
- Simultaneous requests are resolved purely by ptr order. Index 0 wins first after reset.
- X/illegal: none. Unused owner values cannot occur for non-power-of-2 N_REQ because pick wraps modulo N_REQ.

Decomposition:
- Shared package/include flop_arb_pkg:
  - state encoding localparams ST_IDLE/ST_OWN;
  - the IDX_W=$clog2(N_REQ) helper.
- Sub-module rr_pick: combinational rotating-priority search (inputs req, ptr, exclude_en, exclude_idx; outputs found, idx), instantiated once.
- Top holds the FSM, ptr, hold_cnt and the q/qi flops.

Test Plan:
1. Reset: assert rst mid-ownership with req=4'b0011 -> grant=0, busy=0, q=qi=0 immediately (async). After release, req[1] alone gives grant=4'b0010 one edge later.
2. Single requester: req=4'b0100, s_in[2]=1, r_in[2]=0 for 12 cycles -> grant=4'b0100 at edge 1. q=1, qi=0 from edge 2. Grant held all 12 cycles (hold saturates, no rotation).
3. Forced rotation, MAX_HOLD=8: req=4'b0011 held -> owner 0 for exactly 8 loads, then owner 1 for 8 loads, then owner 0 again. No idle gap between owners.
4. Simultaneous from reset: req=4'b1111 with each requester dropping after one load -> grant order 0,1,2,3,0. ptr wraps 3->0.
5. Early release: owner 2 drops req after 3 loads while req[0]=1 -> grant=4'b0001 on the next edge. q/qi unchanged on the drop edge. Next load uses s_in[0]/r_in[0].
6. Return to idle: the sole owner drops req -> busy=0, grant=0 on the next edge, q/qi hold their last values. A later req[3] gives grant=4'b1000.
